// File: rtl/lsu2ram.sv
// lsu2ram: single-outstanding load/store engine between the EXU and WBU stages.
// Captures one operation, issues one RAM request/response, formats the result
// and holds it for the WBU.
module lsu2ram #(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  i_sys_clk,
    input  logic                  i_sys_rst,
    input  logic                  i_exu_valid,
    output logic                  o_exu_ready,
    input  logic [ADDR_WIDTH-1:0] i_exu_pc,
    input  logic [31:0]           i_exu_res,
    input  logic [31:0]           i_exu_rs2_data,
    input  logic                  i_exu_ctr_ram_rd_en,
    input  logic                  i_exu_ctr_ram_wr_en,
    input  logic [1:0]            i_exu_ctr_ram_byt,
    input  logic                  i_exu_ctr_ram_sext,
    output logic                  o_ram_req_valid,
    input  logic                  i_ram_req_ready,
    output logic                  o_ram_wr_en,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    output logic [31:0]           o_ram_wr_data,
    output logic [3:0]            o_ram_wr_mask,
    input  logic                  i_ram_rsp_valid,
    input  logic [31:0]           i_ram_rd_data,
    output logic                  o_wbu_valid,
    input  logic                  i_wbu_ready,
    output logic [ADDR_WIDTH-1:0] o_wbu_pc,
    output logic [31:0]           o_wbu_data,
    output logic                  o_wbu_err
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

    state_e state_q, state_d;

    logic [ADDR_WIDTH-1:0] pc_q, addr_q;
    logic [31:0]           wdata_q, data_q;
    logic [3:0]            mask_q;
    logic                  wr_en_q, err_q, sext_q;
    logic [1:0]            byt_q, lane_q;

    logic        in_wr, in_mem, in_misal;
    logic [31:0] in_wdata;
    logic [3:0]  in_mask;
    logic [31:0] rd_shifted, ld_data;
    logic        accept, req_fire, rsp_fire, wbu_fire;

    assign accept   = (state_q == StIdle) && i_exu_valid;
    assign req_fire = (state_q == StReq) && i_ram_req_ready;
    assign rsp_fire = (state_q == StWait) && i_ram_rsp_valid;
    assign wbu_fire = (state_q == StDone) && i_wbu_ready;

    // Classify the incoming operation and format store data/mask per size and lane.
    always_comb begin
        in_wr    = i_exu_ctr_ram_wr_en;
        in_mem   = (i_exu_ctr_ram_wr_en || i_exu_ctr_ram_rd_en) && (i_exu_ctr_ram_byt != 2'd0);
        in_misal = in_mem && (((i_exu_ctr_ram_byt == 2'd2) && i_exu_res[0]) ||
                              ((i_exu_ctr_ram_byt == 2'd3) && (i_exu_res[1:0] != 2'b00)));
        in_wdata = i_exu_rs2_data;
        in_mask  = 4'b1111;
        unique case (i_exu_ctr_ram_byt)
            2'd1: begin
                in_wdata = {4{i_exu_rs2_data[7:0]}};
                in_mask  = 4'b0001 << i_exu_res[1:0];
            end
            2'd2: begin
                in_wdata = {2{i_exu_rs2_data[15:0]}};
                in_mask  = 4'b0011 << i_exu_res[1:0];
            end
            default: begin
                in_wdata = i_exu_rs2_data;
                in_mask  = 4'b1111;
            end
        endcase
        // Loads never enable byte lanes.
        if (!in_wr) begin
            in_mask = 4'b0000;
        end
    end

    // Extract the addressed byte/half from the read word and extend it.
    always_comb begin
        rd_shifted = i_ram_rd_data >> {lane_q, 3'b000};
        unique case (byt_q)
            2'd1:    ld_data = {{24{sext_q & rd_shifted[7]}}, rd_shifted[7:0]};
            2'd2:    ld_data = {{16{sext_q & rd_shifted[15]}}, rd_shifted[15:0]};
            default: ld_data = i_ram_rd_data;
        endcase
    end

    // State register.
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept)   state_d = (in_mem && !in_misal) ? StReq : StDone;
            StReq:  if (req_fire) state_d = StWait;
            StWait: if (rsp_fire) state_d = StDone;
            StDone: if (wbu_fire) state_d = StIdle;
            default:              state_d = StIdle;
        endcase
    end

    // Captured operation and result registers.
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            pc_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            mask_q  <= '0;
            wr_en_q <= 1'b0;
            byt_q   <= '0;
            lane_q  <= '0;
            sext_q  <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
        end else if (accept) begin
            pc_q    <= i_exu_pc;
            addr_q  <= {i_exu_res[ADDR_WIDTH-1:2], 2'b00};
            wdata_q <= in_wdata;
            mask_q  <= in_mask;
            wr_en_q <= in_wr;
            byt_q   <= i_exu_ctr_ram_byt;
            lane_q  <= i_exu_res[1:0];
            sext_q  <= i_exu_ctr_ram_sext;
            err_q   <= in_misal;
            // Non-memory ops write back the ALU result; misaligned ones return zero.
            data_q  <= in_mem ? 32'd0 : i_exu_res;
        end else if (rsp_fire) begin
            data_q  <= wr_en_q ? 32'd0 : ld_data;
        end
    end

    // Outputs decoded from registered state; forced low while reset is held.
    always_comb begin
        o_exu_ready     = !i_sys_rst && (state_q == StIdle);
        o_ram_req_valid = !i_sys_rst && (state_q == StReq);
        o_wbu_valid     = !i_sys_rst && (state_q == StDone);
        o_ram_wr_en     = i_sys_rst ? 1'b0 : wr_en_q;
        o_ram_addr      = i_sys_rst ? '0 : addr_q;
        o_ram_wr_data   = i_sys_rst ? '0 : wdata_q;
        o_ram_wr_mask   = i_sys_rst ? '0 : mask_q;
        o_wbu_pc        = i_sys_rst ? '0 : pc_q;
        o_wbu_data      = i_sys_rst ? '0 : data_q;
        o_wbu_err       = i_sys_rst ? 1'b0 : err_q;
    end

endmodule

// File: tb/tb_lsu2ram.sv
// Self-checking bench for lsu2ram: directed scenarios plus randomized ops with
// random RAM/WBU stalls, checked against a byte-lane arithmetic model.
module tb_lsu2ram;

    logic        clk = 1'b0;
    logic        rst;
    logic        exu_valid, exu_ready;
    logic [31:0] exu_pc, exu_res, exu_rs2;
    logic        rd_en, wr_en;
    logic [1:0]  byt;
    logic        sext;
    logic        req_valid, req_ready, ram_wr_en;
    logic [31:0] ram_addr, ram_wdata;
    logic [3:0]  ram_mask;
    logic        rsp_valid;
    logic [31:0] rd_data;
    logic        wbu_valid, wbu_ready;
    logic [31:0] wbu_pc, wbu_data;
    logic        wbu_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    lsu2ram #(.ADDR_WIDTH(32)) dut (
        .i_sys_clk           (clk),
        .i_sys_rst           (rst),
        .i_exu_valid         (exu_valid),
        .o_exu_ready         (exu_ready),
        .i_exu_pc            (exu_pc),
        .i_exu_res           (exu_res),
        .i_exu_rs2_data      (exu_rs2),
        .i_exu_ctr_ram_rd_en (rd_en),
        .i_exu_ctr_ram_wr_en (wr_en),
        .i_exu_ctr_ram_byt   (byt),
        .i_exu_ctr_ram_sext  (sext),
        .o_ram_req_valid     (req_valid),
        .i_ram_req_ready     (req_ready),
        .o_ram_wr_en         (ram_wr_en),
        .o_ram_addr          (ram_addr),
        .o_ram_wr_data       (ram_wdata),
        .o_ram_wr_mask       (ram_mask),
        .i_ram_rsp_valid     (rsp_valid),
        .i_ram_rd_data       (rd_data),
        .o_wbu_valid         (wbu_valid),
        .i_wbu_ready         (wbu_ready),
        .o_wbu_pc            (wbu_pc),
        .o_wbu_data          (wbu_data),
        .o_wbu_err           (wbu_err)
    );

    // Reference model: sizes in bytes, lanes as byte offsets, plain arithmetic.
    function automatic void model(input logic [31:0] res, rs2, rdd, input logic rd, wr,
                                  input logic [1:0] b, input logic sx,
                                  output bit is_mem, output bit err,
                                  output logic [31:0] data, output logic [31:0] wd,
                                  output logic [3:0] mask);
        int n, lane, nn;
        longint v, m;
        n      = (b == 2'd3) ? 4 : int'(b);
        nn     = (n == 0) ? 4 : n;
        lane   = int'(res[1:0]);
        is_mem = (rd || wr) && (b != 2'd0);
        err    = 1'b0;
        if (is_mem && ((res % nn) != 0)) err = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wd[8*i +: 8] = rs2[8*(i % nn) +: 8];
            mask[i]      = wr && (i >= lane) && (i < lane + nn);
        end
        if (!is_mem) data = res;
        else if (err || wr) data = 32'd0;
        else begin
            m = (longint'(1) << (8 * n)) - 1;
            v = (longint'(rdd) >> (8 * lane)) & m;
            if (sx && n < 4 && v[8*n-1]) v = v | ~m;
            data = v[31:0];
        end
        if (err) is_mem = 1'b0;
    endfunction

    task automatic run_op(input string name, input logic [31:0] pc, res, rs2, rdd,
                          input logic rd, wr, input logic [1:0] b, input logic sx,
                          input int rq_st, rs_st, wb_st);
        bit          is_mem, err;
        logic [31:0] exp_data, exp_wd;
        logic [3:0]  exp_mask;
        model(res, rs2, rdd, rd, wr, b, sx, is_mem, err, exp_data, exp_wd, exp_mask);
        n_checks++;
        if (exu_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL %s idle_ready: got %b want 1", name, exu_ready);
        end
        exu_valid = 1'b1; exu_pc = pc; exu_res = res; exu_rs2 = rs2;
        rd_en = rd; wr_en = wr; byt = b; sext = sx;
        @(posedge clk); #1;
        // Garbage on the EXU side must not disturb the captured op.
        exu_valid = $urandom_range(0, 1); exu_pc = $urandom; exu_res = $urandom;
        exu_rs2 = $urandom; rd_en = $urandom_range(0, 1); wr_en = $urandom_range(0, 1);
        byt = 2'($urandom); sext = $urandom_range(0, 1);
        if (is_mem) begin
            for (int c = 0; c <= rq_st; c++) begin
                n_checks++;
                if ({req_valid, ram_wr_en, ram_addr, ram_mask, wbu_valid, exu_ready} !==
                    {1'b1, wr, res & 32'hFFFF_FFFC, exp_mask, 1'b0, 1'b0}) begin
                    n_errors++;
                    $display("FAIL %s req[%0d]: got v=%b we=%b a=%h m=%b wv=%b rdy=%b want v=1 we=%b a=%h m=%b wv=0 rdy=0",
                             name, c, req_valid, ram_wr_en, ram_addr, ram_mask, wbu_valid,
                             exu_ready, wr, res & 32'hFFFF_FFFC, exp_mask);
                end
                if (wr) begin
                    n_checks++;
                    if (ram_wdata !== exp_wd) begin
                        n_errors++;
                        $display("FAIL %s wdata[%0d]: got %h want %h", name, c, ram_wdata, exp_wd);
                    end
                end
                req_ready = (c == rq_st);
                rsp_valid = (c == rq_st) ? 1'b0 : 1'($urandom_range(0, 1));
                rd_data   = $urandom;
                @(posedge clk); #1;
            end
            req_ready = 1'b0;
            for (int c = 0; c <= rs_st; c++) begin
                n_checks++;
                if ({req_valid, wbu_valid, exu_ready} !== 3'b000) begin
                    n_errors++;
                    $display("FAIL %s wait[%0d]: got req=%b wv=%b rdy=%b want 000",
                             name, c, req_valid, wbu_valid, exu_ready);
                end
                rsp_valid = (c == rs_st);
                rd_data   = (c == rs_st) ? rdd : $urandom;
                req_ready = $urandom_range(0, 1);
                @(posedge clk); #1;
            end
            rsp_valid = 1'b0; req_ready = 1'b0;
        end
        for (int c = 0; c <= wb_st; c++) begin
            n_checks++;
            if ({wbu_valid, wbu_pc, wbu_data, wbu_err, req_valid, exu_ready} !==
                {1'b1, pc, exp_data, err, 1'b0, 1'b0}) begin
                n_errors++;
                $display("FAIL %s done[%0d]: got v=%b pc=%h d=%h e=%b req=%b rdy=%b want v=1 pc=%h d=%h e=%b req=0 rdy=0",
                         name, c, wbu_valid, wbu_pc, wbu_data, wbu_err, req_valid, exu_ready,
                         pc, exp_data, err);
            end
            wbu_ready = (c == wb_st);
            exu_valid = (c == wb_st) ? 1'b0 : 1'($urandom_range(0, 1));
            req_ready = $urandom_range(0, 1);
            rsp_valid = $urandom_range(0, 1);
            @(posedge clk); #1;
        end
        wbu_ready = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0; exu_valid = 1'b0;
        n_checks++;
        if ({wbu_valid, exu_ready, req_valid} !== 3'b010) begin
            n_errors++;
            $display("FAIL %s after_wbu: got wv=%b rdy=%b req=%b want 0 1 0",
                     name, wbu_valid, exu_ready, req_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; exu_valid = 1'b1; exu_res = 32'h0000_1000; rd_en = 1'b1; byt = 2'd3;
        wbu_ready = 1'b0; req_ready = 1'b1; rsp_valid = 1'b1; rd_data = $urandom;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({exu_ready, req_valid, ram_wr_en, ram_addr, ram_wdata, ram_mask, wbu_valid,
             wbu_pc, wbu_data, wbu_err} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: got rdy=%b req=%b we=%b a=%h wd=%h m=%b wv=%b pc=%h d=%h e=%b want all 0",
                     exu_ready, req_valid, ram_wr_en, ram_addr, ram_wdata, ram_mask, wbu_valid,
                     wbu_pc, wbu_data, wbu_err);
        end
        exu_valid = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0; rst = 1'b0;
        #1;
        n_checks++;
        if ({exu_ready, req_valid, wbu_valid} !== 3'b100) begin
            n_errors++;
            $display("FAIL reset_release: got rdy=%b req=%b wv=%b want 1 0 0",
                     exu_ready, req_valid, wbu_valid);
        end
    endtask

    task automatic test_passthrough();
        run_op("passthrough", 32'h0000_0100, 32'h1234_5678, 32'h0, 32'h0,
               1'b0, 1'b0, 2'd2, 1'b0, 0, 0, 0);
    endtask

    task automatic test_signed_byte_load();
        run_op("sbyte_load", 32'h0000_0104, 32'h0000_1003, 32'h0, 32'h80AB_CDEF,
               1'b1, 1'b0, 2'd1, 1'b1, 0, 0, 0);
    endtask

    task automatic test_half_store();
        run_op("half_store", 32'h0000_0108, 32'h0000_2002, 32'hDEAD_BEEF, 32'h0,
               1'b0, 1'b1, 2'd2, 1'b0, 0, 0, 0);
    endtask

    task automatic test_backpressure();
        run_op("backpressure", 32'h0000_010C, 32'h0000_4006, 32'h0, 32'h1357_9BDF,
               1'b1, 1'b0, 2'd2, 1'b1, 3, 0, 2);
    endtask

    task automatic test_misaligned();
        run_op("misaligned", 32'h0000_0110, 32'h0000_3001, 32'h0, 32'h0,
               1'b1, 1'b0, 2'd3, 1'b0, 0, 0, 0);
    endtask

    task automatic test_reset_mid();
        exu_valid = 1'b1; exu_pc = 32'h0000_0200; exu_res = 32'h0000_5004;
        rd_en = 1'b1; wr_en = 1'b0; byt = 2'd3; sext = 1'b0;
        @(posedge clk); #1;
        exu_valid = 1'b0; req_ready = 1'b1;
        @(posedge clk); #1;
        req_ready = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({exu_ready, req_valid, ram_wr_en, ram_addr, ram_wdata, ram_mask, wbu_valid,
             wbu_pc, wbu_data, wbu_err} !== '0) begin
            n_errors++;
            $display("FAIL reset_mid_outputs: got rdy=%b req=%b a=%h wv=%b pc=%h d=%h want all 0",
                     exu_ready, req_valid, ram_addr, wbu_valid, wbu_pc, wbu_data);
        end
        rst = 1'b0; rsp_valid = 1'b1; rd_data = 32'hCAFE_F00D;
        @(posedge clk); #1;
        rsp_valid = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({exu_ready, req_valid, wbu_valid} !== 3'b100) begin
            n_errors++;
            $display("FAIL reset_mid_stray_rsp: got rdy=%b req=%b wv=%b want 1 0 0",
                     exu_ready, req_valid, wbu_valid);
        end
        run_op("after_reset", 32'h0000_0204, 32'h0000_6000, 32'h0, 32'h0BAD_F00D,
               1'b1, 1'b0, 2'd3, 1'b0, 0, 1, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            run_op("random", $urandom, $urandom, $urandom, $urandom,
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom),
                   1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3));
        end
    endtask

    initial begin
        rst = 1'b1; exu_valid = 1'b0; exu_pc = '0; exu_res = '0; exu_rs2 = '0;
        rd_en = 1'b0; wr_en = 1'b0; byt = '0; sext = 1'b0;
        req_ready = 1'b0; rsp_valid = 1'b0; rd_data = '0; wbu_ready = 1'b0;
        #1;
        test_reset();
        test_passthrough();
        test_signed_byte_load();
        test_half_store();
        test_backpressure();
        test_misaligned();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lsu2ram.md
# lsu2ram

Load/store access engine on the LSU side of the EXU→LSU pipeline boundary. It accepts one registered memory operation per valid/ready handshake and drives a request/response RAM port. It aligns store data and byte masks, then extracts and sign- or zero-extends load data. It presents the result to the WBU stage through a second valid/ready handshake. One operation is in flight at a time; the module applies backpressure upstream until the WBU takes the result.

## Interface
- `ADDR_WIDTH`, 32, byte-address width; data path fixed at 32 bits, 4 byte lanes.
- `i_sys_clk`  in  1  clock; one clock, all logic on rising edge.
- `i_sys_rst`  in  1  reset; synchronous, active-high.
- `i_exu_valid`  in  1  upstream operation valid.
- `o_exu_ready`  out  1  engine can accept an operation.
- `i_exu_pc`  in  ADDR_WIDTH  instruction PC.
- `i_exu_res`  in  32  ALU result: effective address for memory ops, writeback value otherwise.
- `i_exu_rs2_data`  in  32  store data.
- `i_exu_ctr_ram_rd_en`  in  1  load.
- `i_exu_ctr_ram_wr_en`  in  1  store; wins if both are set.
- `i_exu_ctr_ram_byt`  in  2  size: 0=none, 1=byte, 2=half, 3=word.
- `i_exu_ctr_ram_sext`  in  1  sign-extend the load result.
- `o_ram_req_valid`  out  1  RAM request valid.
- `i_ram_req_ready`  in  1  RAM accepts the request.
- `o_ram_wr_en`  out  1  request is a write.
- `o_ram_addr`  out  ADDR_WIDTH  word-aligned address.
- `o_ram_wr_data`  out  32  lane-replicated store data.
- `o_ram_wr_mask`  out  4  byte-lane write enables.
- `i_ram_rsp_valid`  in  1  response/ack for the accepted request.
- `i_ram_rd_data`  in  32  read word; valid with `i_ram_rsp_valid`.
- `o_wbu_valid`  out  1  result valid.
- `i_wbu_ready`  in  1  WBU accepts the result.
- `o_wbu_pc`  out  ADDR_WIDTH  PC of the result.
- `o_wbu_data`  out  32  writeback data.
- `o_wbu_err`  out  1  misaligned access; no RAM access was made.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE. Reset state is IDLE.
- IDLE: `o_exu_ready`=1.
  - On `i_exu_valid`, capture all `i_exu_*` inputs.
  - Classify the operation:
    - No memory op (both enables 0, or byt=0): `o_wbu_data`=res, go to DONE.
    - Misaligned (half with addr[0]=1, or word with addr[1:0]≠0): err=1, data=0, go to DONE.
    - Otherwise: go to REQ.
- REQ:
  - `o_ram_req_valid`=1.
  - addr, wr_en, wr_data and mask are held stable from captured registers until `i_ram_req_ready`.
  - On `i_ram_req_ready`, go to WAIT.
- WAIT: on `i_ram_rsp_valid`, go to DONE.
  - Load: lane = addr[1:0]. Extract byte or half, then zero- or sign-extend per sext. Word is passed unchanged.
  - Store: `o_wbu_data`=0.
- DONE: `o_wbu_valid`=1, pc/data/err held stable. On `i_wbu_ready`, go to IDLE.
- Store formatting:
  - byte: data={4{rs2[7:0]}}, mask=4'b0001<<addr[1:0].
  - half: data={2{rs2[15:0]}}, mask=4'b0011<<addr[1:0].
  - word: data=rs2, mask=4'b1111.
  - Loads: mask=0.
- `o_ram_addr`={res[ADDR_WIDTH-1:2],2'b00}.
- `i_ram_rsp_valid` outside WAIT is ignored.
- `i_ram_req_ready` outside REQ is ignored.

## Timing
- Reset values:
  - All outputs are 0 while `i_sys_rst` is high, including `o_exu_ready`.
  - Captured registers are cleared.
  - State returns to IDLE.
- Reset mid-operation abandons the op: the RAM request drops the next cycle and any later response is ignored.
- All handshake outputs are decoded from registered state only; there is no combinational path from any `i_*_ready` or `i_*_valid` to an output.
- Non-memory op: accepted at cycle N, `o_wbu_valid` at N+1.
- Memory op with zero-wait RAM:
  - accepted at N;
  - `o_ram_req_valid` at N+1, ready at N+1;
  - rsp at N+2;
  - `o_wbu_valid` at N+3.
- Each extra stall cycle of req_ready, rsp_valid or wbu_ready adds exactly one cycle.
- Throughput: after a WBU handshake at cycle M, `o_exu_ready`=1 at M+1. There is no same-cycle re-accept.
- A response in the same cycle the request is accepted is illegal and unsupported.

## Test plan
- ALU passthrough: valid, res=0x1234_5678, enables 0 → 1 cycle later wbu_valid=1, data=0x1234_5678, no RAM request.
- Signed byte load: addr=0x0000_1003, byt=1, sext=1, rd_data=0x80AB_CDEF → data=0xFFFF_FF80, o_ram_addr=0x0000_1000, latency 3 cycles with zero-wait RAM.
- Half store: addr=0x0000_2002, byt=2, rs2=0xDEAD_BEEF → wr_data=0xBEEF_BEEF, mask=4'b1100, wr_en=1.
- Backpressure: req_ready low for 3 cycles, then wbu_ready low for 2 cycles → req outputs stable throughout, o_exu_ready=0, result delivered exactly once.
- Misaligned word load: addr=0x0000_3001 → err=1 at N+1, o_ram_req_valid never asserted.
- Reset while in WAIT → all outputs 0 the next cycle; a later stray rsp_valid is ignored; the next op completes normally.
